// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline-stage buffer: default field widths,
// the NOP instruction value and the default {pc, inst, bubble} entry layout.
package pipe_pkg;

    localparam int PC_W_DEF   = 16;
    localparam int INST_W_DEF = 16;

    localparam logic [INST_W_DEF-1:0] NOP_INST_DEF = '0;

    typedef struct packed {
        logic [PC_W_DEF-1:0]   pc;
        logic [INST_W_DEF-1:0] inst;
        logic                  bubble;
    } entry_t;

endpackage

// File: rtl/pipe_fifo_ctrl.sv
// Pointer, occupancy and handshake control for the pipeline-stage buffer.
// Flush outranks push and pop; a full buffer refuses pushes even when a pop
// happens in the same cycle, so in_ready depends only on registered count.
module pipe_fifo_ctrl #(
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    input  logic             out_ready,
    output logic             in_ready,
    output logic             out_valid,
    output logic             push,
    output logic             pop,
    output logic [PTR_W-1:0] wr_ptr,
    output logic [PTR_W-1:0] rd_ptr,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    // Handshake qualifiers derived from registered occupancy only.
    always_comb begin
        in_ready  = (count != FULL_CNT);
        out_valid = (count != '0);
        push      = in_valid && in_ready && !flush;
        pop       = out_valid && out_ready && !flush;
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/pipe_stage_fifo.sv
// Elastic buffer between datapath stages (first user: IF->ID). Holds up to
// DEPTH {pc, inst, bubble} entries with show-ahead outputs; an empty buffer
// presents pc=0, inst=NOP_INST, bubble=0 regardless of stale storage.
module pipe_stage_fifo
    import pipe_pkg::*;
#(
    parameter  int                PC_W     = PC_W_DEF,
    parameter  int                INST_W   = INST_W_DEF,
    parameter  int                DEPTH    = 4,
    parameter  logic [INST_W-1:0] NOP_INST = INST_W'(NOP_INST_DEF),
    localparam int                PTR_W    = $clog2(DEPTH),
    localparam int                CNT_W    = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PC_W-1:0]   pc_in,
    input  logic [INST_W-1:0] inst_in,
    input  logic              bubble_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PC_W-1:0]   pc_out,
    output logic [INST_W-1:0] inst_out,
    output logic              bubble_out,
    output logic [CNT_W-1:0]  count
);

    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic [INST_W-1:0] inst;
        logic              bubble;
    } slot_t;

    slot_t            mem [DEPTH];
    slot_t            wr_slot;
    logic             push;
    logic             pop;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    pipe_fifo_ctrl #(
        .DEPTH (DEPTH)
    ) u_ctrl (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .out_ready (out_ready),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .push      (push),
        .pop       (pop),
        .wr_ptr    (wr_ptr),
        .rd_ptr    (rd_ptr),
        .count     (count)
    );

    // Bubbles carry the NOP encoding so downstream never sees a stale opcode.
    always_comb begin
        wr_slot.pc     = pc_in;
        wr_slot.inst   = bubble_in ? NOP_INST : inst_in;
        wr_slot.bubble = bubble_in;
    end

    // Storage is never reset; validity is tracked entirely by count.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr_slot;
    end

    // Show-ahead head presentation, forced to idle values while empty.
    always_comb begin
        pc_out     = '0;
        inst_out   = NOP_INST;
        bubble_out = 1'b0;
        if (out_valid) begin
            pc_out     = mem[rd_ptr].pc;
            inst_out   = mem[rd_ptr].inst;
            bubble_out = mem[rd_ptr].bubble;
        end
    end

endmodule

// File: tb/tb_pipe_stage_fifo.sv
// Bench for pipe_stage_fifo: vector table, directed corner sequences and a
// randomized stream checked against a queue-based reference model.
module tb_pipe_stage_fifo;
    import pipe_pkg::*;

    localparam int DEPTH = 4;
    localparam int CNT_W = 3;
    localparam logic [15:0] NOP = 16'h0000;

    logic              clk = 1'b0;
    logic              rst;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [15:0]       pc_in;
    logic [15:0]       inst_in;
    logic              bubble_in;
    logic              out_valid;
    logic              out_ready;
    logic [15:0]       pc_out;
    logic [15:0]       inst_out;
    logic              bubble_out;
    logic [CNT_W-1:0]  count;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pipe_stage_fifo #(
        .PC_W     (16),
        .INST_W   (16),
        .DEPTH    (DEPTH),
        .NOP_INST (NOP)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .pc_in      (pc_in),
        .inst_in    (inst_in),
        .bubble_in  (bubble_in),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .pc_out     (pc_out),
        .inst_out   (inst_out),
        .bubble_out (bubble_out),
        .count      (count)
    );

    typedef struct {
        logic        fl;
        logic        iv;
        logic [15:0] pc;
        logic [15:0] inst;
        logic        bub;
        logic        ordy;
        logic        e_ov;
        logic [15:0] e_pc;
        logic [15:0] e_inst;
        logic        e_b;
        logic [2:0]  e_cnt;
        logic        e_ir;
    } vec_t;

    vec_t vecs[11];

    function automatic vec_t mk(logic fl, logic iv, logic [15:0] pc, logic [15:0] inst,
                                logic bub, logic ordy, logic e_ov, logic [15:0] e_pc,
                                logic [15:0] e_inst, logic e_b, logic [2:0] e_cnt, logic e_ir);
        vec_t v;
        v.fl = fl; v.iv = iv; v.pc = pc; v.inst = inst; v.bub = bub; v.ordy = ordy;
        v.e_ov = e_ov; v.e_pc = e_pc; v.e_inst = e_inst; v.e_b = e_b;
        v.e_cnt = e_cnt; v.e_ir = e_ir;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic expect_out(input string tag, input logic ov, input logic [15:0] pc,
                              input logic [15:0] inst, input logic b, input logic [2:0] cnt,
                              input logic ir);
        chk({tag, ".out_valid"},  32'(out_valid),  32'(ov));
        chk({tag, ".pc_out"},     32'(pc_out),     32'(pc));
        chk({tag, ".inst_out"},   32'(inst_out),   32'(inst));
        chk({tag, ".bubble_out"}, 32'(bubble_out), 32'(b));
        chk({tag, ".count"},      32'(count),      32'(cnt));
        chk({tag, ".in_ready"},   32'(in_ready),   32'(ir));
    endtask

    task automatic drive(input logic fl, input logic iv, input logic [15:0] pc,
                         input logic [15:0] inst, input logic bub, input logic ordy);
        flush     = fl;
        in_valid  = iv;
        pc_in     = pc;
        inst_in   = inst;
        bubble_in = bub;
        out_ready = ordy;
    endtask

    // Inputs change at negedge; results are sampled at the following negedge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    entry_t q[$];
    entry_t cur;
    entry_t head;

    initial begin
        rst = 1'b0;
        drive(0, 0, 16'h0, 16'h0, 0, 0);
        @(negedge clk);
        @(negedge clk);
        expect_out("reset", 0, 16'h0, NOP, 0, 3'd0, 1);
        rst = 1'b1;
        @(negedge clk);

        // Table: push, mixed push/pop with a bubble, full refusal, flush, empty push.
        vecs[0]  = mk(0, 1, 16'h10, 16'h1111, 0, 0,  1, 16'h10, 16'h1111, 0, 3'd1, 1);
        vecs[1]  = mk(0, 1, 16'h11, 16'h2222, 0, 0,  1, 16'h10, 16'h1111, 0, 3'd2, 1);
        vecs[2]  = mk(0, 1, 16'h12, 16'hABCD, 1, 1,  1, 16'h11, 16'h2222, 0, 3'd2, 1);
        vecs[3]  = mk(0, 0, 16'h00, 16'h0000, 0, 1,  1, 16'h12, NOP,      1, 3'd1, 1);
        vecs[4]  = mk(0, 1, 16'h13, 16'h3333, 0, 0,  1, 16'h12, NOP,      1, 3'd2, 1);
        vecs[5]  = mk(0, 1, 16'h14, 16'h4444, 0, 0,  1, 16'h12, NOP,      1, 3'd3, 1);
        vecs[6]  = mk(0, 1, 16'h15, 16'h5555, 0, 0,  1, 16'h12, NOP,      1, 3'd4, 0);
        vecs[7]  = mk(0, 1, 16'h16, 16'h6666, 0, 1,  1, 16'h13, 16'h3333, 0, 3'd3, 1);
        vecs[8]  = mk(1, 1, 16'h17, 16'h7777, 0, 1,  0, 16'h00, NOP,      0, 3'd0, 1);
        vecs[9]  = mk(0, 1, 16'h18, 16'h8888, 0, 1,  1, 16'h18, 16'h8888, 0, 3'd1, 1);
        vecs[10] = mk(0, 0, 16'h00, 16'h0000, 0, 1,  0, 16'h00, NOP,      0, 3'd0, 1);
        for (int i = 0; i < 11; i++) begin
            drive(vecs[i].fl, vecs[i].iv, vecs[i].pc, vecs[i].inst, vecs[i].bub, vecs[i].ordy);
            tick();
            expect_out($sformatf("vec%0d", i), vecs[i].e_ov, vecs[i].e_pc, vecs[i].e_inst,
                       vecs[i].e_b, vecs[i].e_cnt, vecs[i].e_ir);
        end

        // Fill to full, fifth push ignored, drain in order.
        for (int i = 0; i < 4; i++) begin
            drive(0, 1, 16'h10 + 16'(i), 16'h0100 + 16'(i), 0, 0);
            tick();
        end
        expect_out("full", 1, 16'h10, 16'h0100, 0, 3'd4, 0);
        drive(0, 1, 16'h14, 16'h0104, 0, 0);
        tick();
        expect_out("full_fifth", 1, 16'h10, 16'h0100, 0, 3'd4, 0);
        drive(0, 0, 16'h0, 16'h0, 0, 1);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("drain%0d.pc_out", i), 32'(pc_out), 32'(16'h10 + 16'(i)));
            chk($sformatf("drain%0d.out_valid", i), 32'(out_valid), 32'd1);
            tick();
        end
        expect_out("drained", 0, 16'h0, NOP, 0, 3'd0, 1);

        // Simultaneous push/pop at count=2, pointers wrap repeatedly.
        drive(0, 1, 16'h40, 16'h0040, 0, 0); tick();
        drive(0, 1, 16'h41, 16'h0041, 0, 0); tick();
        for (int i = 0; i < 10; i++) begin
            drive(0, 1, 16'h42 + 16'(i), 16'h0042 + 16'(i), 0, 1);
            tick();
            chk($sformatf("pp%0d.count", i), 32'(count), 32'd2);
            chk($sformatf("pp%0d.pc_out", i), 32'(pc_out), 32'(16'h41 + 16'(i)));
        end
        drive(0, 0, 16'h0, 16'h0, 0, 1);
        chk("pp_tail0.pc_out", 32'(pc_out), 32'h4A);
        tick();
        chk("pp_tail1.pc_out", 32'(pc_out), 32'h4B);
        tick();
        chk("pp_tail.out_valid", 32'(out_valid), 32'd0);

        // Bubble entry.
        drive(0, 1, 16'h20, 16'hABCD, 1, 0);
        tick();
        expect_out("bubble", 1, 16'h20, NOP, 1, 3'd1, 1);
        drive(0, 0, 16'h0, 16'h0, 0, 1);
        tick();

        // Flush with push and pop at count=3.
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 16'h30 + 16'(i), 16'h0030 + 16'(i), 0, 0);
            tick();
        end
        chk("pre_flush.count", 32'(count), 32'd3);
        drive(1, 1, 16'h33, 16'h0033, 0, 1);
        tick();
        expect_out("flush", 0, 16'h0, NOP, 0, 3'd0, 1);
        drive(0, 0, 16'h0, 16'h0, 0, 1);
        tick();
        expect_out("post_flush", 0, 16'h0, NOP, 0, 3'd0, 1);

        // Asynchronous reset mid-stream, between clock edges.
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 16'h50 + 16'(i), 16'h0050 + 16'(i), 0, 0);
            tick();
        end
        chk("pre_reset.count", 32'(count), 32'd3);
        drive(0, 0, 16'h0, 16'h0, 0, 0);
        @(posedge clk);
        #2 rst = 1'b0;
        #1 expect_out("async_reset", 0, 16'h0, NOP, 0, 3'd0, 1);
        @(negedge clk);
        rst = 1'b1;
        tick();
        expect_out("after_reset", 0, 16'h0, NOP, 0, 3'd0, 1);

        // Random stream of 200 entries against a queue model.
        begin
            int sent = 0;
            int got  = 0;
            int cyc  = 0;
            logic iv, ordy, mpush, mpop;
            ordy = 1'b0;
            cur.pc     = 16'h1000;
            cur.bubble = ($urandom % 4) == 0;
            cur.inst   = 16'($urandom);
            while (got < 200 && cyc < 4000) begin
                if (cyc % 2 == 0) ordy = 1'($urandom % 2);
                iv = (sent < 200) && (($urandom % 4) != 0);
                drive(0, iv, cur.pc, cur.inst, cur.bubble, ordy);
                mpush = iv && (q.size() < DEPTH);
                mpop  = (q.size() > 0) && ordy;
                if (mpop) begin
                    chk($sformatf("stream_pop%0d.pc_out", got), 32'(pc_out), 32'(16'h1000 + 16'(got)));
                    void'(q.pop_front());
                    got++;
                end
                if (mpush) begin
                    entry_t e;
                    e.pc     = cur.pc;
                    e.bubble = cur.bubble;
                    e.inst   = cur.bubble ? NOP : cur.inst;
                    q.push_back(e);
                    sent++;
                    cur.pc     = 16'h1000 + 16'(sent);
                    cur.bubble = ($urandom % 4) == 0;
                    cur.inst   = 16'($urandom);
                end
                tick();
                cyc++;
                if (q.size() > 0) begin
                    head = q[0];
                    expect_out($sformatf("stream%0d", cyc), 1, head.pc, head.inst, head.bubble,
                               3'(q.size()), q.size() < DEPTH);
                end else begin
                    expect_out($sformatf("stream%0d", cyc), 0, 16'h0, NOP, 0, 3'd0, 1);
                end
            end
            chk("stream_received", 32'(got), 32'd200);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
